// File: rtl/wb_bus_pkg.sv
// Shared Wishbone definitions for the instruction-memory slave.
// Covers bus widths, the response tag encoding and the response-pipe entry layout.
package wb_bus_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;

    typedef enum logic {
        RESP_ACK = 1'b0,
        RESP_ERR = 1'b1
    } resp_tag_e;

    typedef struct packed {
        logic             valid;
        resp_tag_e        tag;
        logic             we;
        logic [WB_DW-1:0] data;
    } resp_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response shift register. A synchronous flush drops every
// in-flight entry, so no ack or err is issued for a dropped request.
module wb_resp_pipe
    import wb_bus_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic  i_clk,
    input  logic  i_flush,
    input  logic  i_load,
    input  resp_t i_entry,
    output resp_t o_entry
);

    resp_t stage_q [LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_load ? i_entry : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_entry = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_imem_slave.sv
// Pipelined Wishbone B4 slave serving 32-bit words from on-chip RAM, with
// fixed read latency, optional wait-state stalls and err for out-of-range addresses.
module wb_imem_slave
  import wb_bus_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LGMEMSZ       = 10,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned WAIT_STATES   = 0,
  parameter string       HEXFILE       = ""
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
  input  logic [WB_DW-1:0]         i_wb_data,
  input  logic [WB_SELW-1:0]       i_wb_sel,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic                     o_wb_err,
  output logic [WB_DW-1:0]         o_wb_data
);

  localparam int unsigned DEPTH = 1 << LGMEMSZ;
  localparam logic [1:0]  WS    = 2'(WAIT_STATES);

  logic [WB_DW-1:0]   mem [DEPTH];
  logic [1:0]         wait_cnt_q, wait_cnt_d;
  logic               stall;
  logic               accept;
  logic               in_range;
  logic [LGMEMSZ-1:0] idx;
  resp_t              new_entry;
  resp_t              last_entry;

  always_comb begin
    stall    = (wait_cnt_q != '0) & i_wb_cyc;
    // Reset has priority over a same-edge request: it is neither stored nor answered.
    accept   = i_wb_cyc & i_wb_stb & ~stall & ~i_rst;
    in_range = (i_wb_addr >> LGMEMSZ) == '0;
    idx      = i_wb_addr[LGMEMSZ-1:0];

    wait_cnt_d = wait_cnt_q;
    if (!i_wb_cyc) begin
      wait_cnt_d = '0;
    end else if (accept) begin
      wait_cnt_d = WS;
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - 2'd1;
    end

    new_entry.valid = 1'b1;
    new_entry.tag   = in_range ? RESP_ACK : RESP_ERR;
    new_entry.we    = i_wb_we;
    new_entry.data  = mem[idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Byte-lane writes; a read in the following cycle sees the updated word.
  always_ff @(posedge i_clk) begin
    if (accept && in_range && i_wb_we) begin
      for (int unsigned n = 0; n < WB_SELW; n++) begin
        if (i_wb_sel[n]) begin
          mem[idx][8*n +: 8] <= i_wb_data[8*n +: 8];
        end
      end
    end
  end

  wb_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .i_clk   (i_clk),
    .i_flush (i_rst | ~i_wb_cyc),
    .i_load  (accept),
    .i_entry (new_entry),
    .o_entry (last_entry)
  );

  always_comb begin
    o_wb_stall = stall;
    o_wb_ack   = last_entry.valid & (last_entry.tag == RESP_ACK);
    o_wb_err   = last_entry.valid & (last_entry.tag == RESP_ERR);
    o_wb_data  = (o_wb_ack && !last_entry.we) ? last_entry.data : '0;
  end

endmodule

// File: tb/tb_wb_imem_slave.sv
// Scoreboard bench for wb_imem_slave: a word-array model predicts every
// response; a negedge monitor pops and compares each ack/err as it appears.
module tb_wb_imem_slave;

    localparam int AW    = 16;
    localparam int LGM   = 6;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << LGM;

    typedef struct {
        int unsigned exp_cyc;
        bit          err;
        bit [31:0]   data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, cyc, stb, we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    sel;
    logic          ack, stall, err;
    logic [31:0]   rdata;

    logic          w_cyc, w_stb;
    logic [AW-1:0] w_addr;
    logic          w_ack, w_stall, w_err;
    logic [31:0]   w_rdata;

    exp_t        q[$];
    bit [31:0]   mdl [DEPTH];
    int unsigned edge_cnt = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned w_acks = 0;
    int unsigned w_errs = 0;
    bit          stall_seen;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    wb_imem_slave #(
        .ADDRESS_WIDTH (AW),
        .LGMEMSZ       (LGM),
        .LATENCY       (LAT),
        .WAIT_STATES   (0)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_wb_err   (err),
        .o_wb_data  (rdata)
    );

    wb_imem_slave #(
        .ADDRESS_WIDTH (AW),
        .LGMEMSZ       (LGM),
        .LATENCY       (LAT),
        .WAIT_STATES   (2)
    ) dut_ws (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_cyc   (w_cyc),
        .i_wb_stb   (w_stb),
        .i_wb_we    (1'b0),
        .i_wb_addr  (w_addr),
        .i_wb_data  (32'h0),
        .i_wb_sel   (4'hF),
        .o_wb_ack   (w_ack),
        .o_wb_stall (w_stall),
        .o_wb_err   (w_err),
        .o_wb_data  (w_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("ack_err_exclusive", 32'(ack & err), 32'h0);
        if (ack || err) begin
            if (q.size() == 0) begin
                check("unexpected_resp", {30'h0, ack, err}, 32'h0);
            end else begin
                e = q.pop_front();
                check("resp_cycle", edge_cnt, e.exp_cyc);
                check("resp_err", 32'(err), 32'(e.err));
                check("resp_data", rdata, e.data);
            end
        end else if (q.size() > 0 && q[0].exp_cyc <= edge_cnt) begin
            e = q.pop_front();
            check("missing_resp", {30'h0, ack, err}, e.err ? 32'h1 : 32'h2);
        end
        if (w_ack) w_acks++;
        if (w_err) w_errs++;
    end

    // Drops predicted responses that would land after the flushing edge.
    task automatic drop_after(input int unsigned n);
        while (q.size() > 0 && q[$].exp_cyc > n) void'(q.pop_back());
    endtask

    task automatic req(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned n;
        int          tries = 0;
        bit          done  = 0;
        bit          inr;
        exp_t        e;
        while (!done) begin
            @(posedge clk); #1;
            cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
            n = edge_cnt;
            #1;
            if (!stall) begin
                done = 1;
                inr = (a >> LGM) == 0;
                if (inr && w) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl[a[LGM-1:0]][8*b +: 8] = d[8*b +: 8];
                end
                e.exp_cyc = n + LAT;
                e.err     = !inr;
                e.data    = (inr && !w) ? mdl[a[LGM-1:0]] : 32'h0;
                q.push_back(e);
            end else begin
                stall_seen = 1;
                tries++;
                if (tries > 20) begin
                    check("stall_timeout", 32'(stall), 32'h0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        stb = 0;
    endtask

    task automatic abort_cyc();
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        drop_after(edge_cnt);
    endtask

    task automatic reset_with_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rst = 1; cyc = 1; stb = 1; we = 1; addr = a; wdata = d; sel = 4'hF;
        drop_after(edge_cnt);
        @(posedge clk); #1;
        rst = 0; stb = 0;
        #1;
        check("post_reset_stall", 32'(stall), 32'h0);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", q.size(), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [8:0]    pat;
        int unsigned acc;
        int unsigned base_acks, base_errs;

        rst = 1; cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
        w_cyc = 0; w_stb = 0; w_addr = '0;
        stall_seen = 0;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_data", rdata, 32'h0);
        repeat (3) @(negedge clk);
        check("idle_ack", 32'(ack), 32'h0);

        for (int i = 0; i < DEPTH; i++) req(1, AW'(i), $urandom, 4'hF);
        idle();
        drain();

        req(1, 'h10, 32'hDEADBEEF, 4'hF);
        req(0, 'h10, 32'h0, 4'hF);
        req(1, 'h10, 32'h000000AA, 4'h1);
        req(0, 'h10, 32'h0, 4'hF);
        idle();
        drain();

        stall_seen = 0;
        for (int i = 0; i < 8; i++) req(0, AW'(i), 32'h0, 4'hF);
        idle();
        check("burst_stall_seen", 32'(stall_seen), 32'h0);
        drain();

        req(1, AW'(DEPTH), 32'h12345678, 4'hF);
        req(0, AW'(DEPTH), 32'h0, 4'hF);
        req(0, 'h0, 32'h0, 4'hF);
        idle();
        drain();

        req(0, 'h1, 32'h0, 4'hF);
        req(0, 'h2, 32'h0, 4'hF);
        req(0, 'h3, 32'h0, 4'hF);
        abort_cyc();
        repeat (3) idle();
        req(0, 'h10, 32'h0, 4'hF);
        idle();
        drain();

        req(0, 'h4, 32'h0, 4'hF);
        req(0, 'h5, 32'h0, 4'hF);
        reset_with_write('h5, 32'hCAFEF00D);
        repeat (2) idle();
        req(0, 'h5, 32'h0, 4'hF);
        req(0, 'h10, 32'h0, 4'hF);
        idle();
        drain();

        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                idle();
            end else if (r < 11) begin
                abort_cyc();
            end else begin
                a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 65535))
                                                 : AW'($urandom_range(0, DEPTH - 1));
                req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            end
        end
        idle();
        drain();

        base_acks = w_acks;
        base_errs = w_errs;
        acc = 0;
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            w_cyc = 1; w_stb = (acc < 3); w_addr = AW'(acc);
            #1;
            pat[8-i] = w_stall;
            if (w_stb && !w_stall) acc++;
        end
        @(posedge clk); #1;
        w_stb = 0;
        repeat (4) @(posedge clk);
        #1 w_cyc = 0;
        @(negedge clk);
        check("ws_stall_pattern", 32'(pat), 32'h0DB);
        check("ws_accepts", acc, 32'd3);
        check("ws_ack_count", w_acks - base_acks, 32'd3);
        check("ws_err_count", w_errs - base_errs, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
